// File: rtl/fitness_pkg.sv
// Shared types and width helper for the truth-table fitness evaluator.
package fitness_pkg;

  typedef enum logic [1:0] {IDLE, SWEEP, FINISH} state_t;

  function automatic int fw_calc(input int n_in, input int n_out);
    return $clog2(n_out * (2 ** n_in) + 1);
  endfunction

endpackage

// File: rtl/fitness_eval_match_count.sv
// Per-vector score: number of circuit outputs that agree with the target bits.
module match_count #(
  parameter  int N_OUT = 2,
  localparam int CW    = $clog2(N_OUT + 1)
) (
  input  logic [N_OUT-1:0] circ_out,
  input  logic [N_OUT-1:0] expected,
  output logic [CW-1:0]    count
);

  always_comb begin
    count = '0;
    for (int unsigned j = 0; j < N_OUT; j++) begin
      if (circ_out[j] == expected[j]) count = count + CW'(1);
    end
  end

endmodule

// File: rtl/fitness_eval.sv
// Sweeps every input vector through the candidate circuit and scores it
// against a latched target truth table.
module fitness_eval
  import fitness_pkg::*;
#(
  parameter  int N_IN   = 6,
  parameter  int N_OUT  = 2,
  parameter  int SETTLE = 0,
  localparam int NV     = 2 ** N_IN,
  localparam int FW     = fw_calc(N_IN, N_OUT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [N_OUT*NV-1:0]   target_tt,
  input  logic [N_OUT-1:0]      circ_out,
  output logic [N_IN-1:0]       test_vec,
  output logic                  busy,
  output logic                  done,
  output logic [FW-1:0]         fitness,
  output logic                  perfect
);

  localparam int CW = $clog2(N_OUT + 1);
  localparam int WW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [FW-1:0]   MAX_FIT   = FW'(N_OUT * NV);
  localparam logic [N_IN-1:0] LAST_VEC  = N_IN'(NV - 1);
  localparam logic [WW-1:0]   LAST_WAIT = WW'(SETTLE);

  state_t                       state, state_next;
  logic [N_OUT-1:0][NV-1:0]     tt_reg;
  logic [N_IN-1:0]              vec;
  logic [WW-1:0]                wait_cnt;
  logic [FW-1:0]                acc, acc_next;
  logic [N_OUT-1:0]             expected;
  logic [CW-1:0]                hits;
  logic                         sample;

  always_comb begin
    expected = '0;
    for (int unsigned j = 0; j < N_OUT; j++) begin
      expected[j] = tt_reg[j][vec];
    end
  end

  match_count #(.N_OUT(N_OUT)) u_match (
    .circ_out (circ_out),
    .expected (expected),
    .count    (hits)
  );

  assign sample   = (state == SWEEP) && (wait_cnt == LAST_WAIT);
  assign acc_next = acc + FW'(hits);

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    test_vec   = '0;
    case (state)
      IDLE:    if (start) state_next = SWEEP;
      SWEEP: begin
        busy     = 1'b1;
        test_vec = vec;
        if (sample && (vec == LAST_VEC)) state_next = FINISH;
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // fitness/perfect are loaded on the edge that takes the final sample so
  // they already hold the complete score during the FINISH (done) cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      vec      <= '0;
      wait_cnt <= '0;
      acc      <= '0;
      fitness  <= '0;
      perfect  <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (start) begin
          tt_reg   <= target_tt;
          vec      <= '0;
          wait_cnt <= '0;
          acc      <= '0;
          fitness  <= '0;
          perfect  <= 1'b0;
        end
        SWEEP: begin
          if (sample) begin
            acc      <= acc_next;
            wait_cnt <= '0;
            if (vec == LAST_VEC) begin
              fitness <= acc_next;
              perfect <= (acc_next == MAX_FIT);
              vec     <= '0;
            end else begin
              vec <= vec + 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fitness_eval.sv
// Scoreboard bench: two evaluator instances (SETTLE=0 and SETTLE=2) driven by
// behavioural candidate circuits and checked against a truth-table model.
module tb_fitness_eval;

  typedef struct {
    int fit;
    int perf;
    int done_cyc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start0, start2;
  logic [127:0] tt0, tt2;
  logic [1:0]   circ0, circ2;
  logic [5:0]   vec0, vec2;
  logic         busy0, busy2, done0, done2, perf0, perf2;
  logic [7:0]   fit0, fit2;

  int           mode0, mode2;
  logic [1:0]   lut [64];
  int           cyc;
  int           checks;
  int           errors;
  exp_t         q0[$];
  exp_t         q2[$];

  fitness_eval #(.N_IN(6), .N_OUT(2), .SETTLE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .target_tt(tt0), .circ_out(circ0),
    .test_vec(vec0), .busy(busy0), .done(done0), .fitness(fit0), .perfect(perf0)
  );

  fitness_eval #(.N_IN(6), .N_OUT(2), .SETTLE(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .target_tt(tt2), .circ_out(circ2),
    .test_vec(vec2), .busy(busy2), .done(done2), .fitness(fit2), .perfect(perf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Candidate circuits: 0 = {parity, and-reduce}, 1 = {bit0, bit0}, else random LUT.
  always_comb begin
    case (mode0)
      0:       circ0 = {^vec0, &vec0};
      1:       circ0 = {vec0[0], vec0[0]};
      default: circ0 = lut[vec0];
    endcase
  end

  always_comb begin
    case (mode2)
      0:       circ2 = {^vec2, &vec2};
      1:       circ2 = {vec2[0], vec2[0]};
      default: circ2 = lut[vec2];
    endcase
  end

  function automatic logic [1:0] model_out(input int mode, input int v);
    logic [5:0] b;
    b = v[5:0];
    case (mode)
      0:       return {^b, &b};
      1:       return {b[0], b[0]};
      default: return lut[b];
    endcase
  endfunction

  function automatic int ref_fit(input int mode, input logic [127:0] tt);
    int         n;
    logic [1:0] o;
    n = 0;
    for (int v = 0; v < 64; v++) begin
      o = model_out(mode, v);
      for (int j = 0; j < 2; j++) if (o[j] == tt[j*64 + v]) n++;
    end
    return n;
  endfunction

  function automatic logic [127:0] mk_tt(input int mode);
    logic [127:0] tt;
    logic [1:0]   o;
    tt = '0;
    for (int v = 0; v < 64; v++) begin
      o = model_out(mode, v);
      for (int j = 0; j < 2; j++) tt[j*64 + v] = o[j];
    end
    return tt;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push0(input int fit, input int dc);
    exp_t e;
    e.fit = fit; e.perf = (fit == 128) ? 1 : 0; e.done_cyc = dc;
    q0.push_back(e);
  endtask

  task automatic push2(input int fit, input int dc);
    exp_t e;
    e.fit = fit; e.perf = (fit == 128) ? 1 : 0; e.done_cyc = dc;
    q2.push_back(e);
  endtask

  always @(negedge clk) begin : mon0
    exp_t e;
    if (done0) begin
      if (q0.size() == 0) begin
        chk("unexpected_done0", 1, 0);
      end else begin
        e = q0.pop_front();
        chk("fitness0", int'(fit0), e.fit);
        chk("perfect0", int'(perf0), e.perf);
        chk("done_cycle0", cyc, e.done_cyc);
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (done2) begin
      if (q2.size() == 0) begin
        chk("unexpected_done2", 1, 0);
      end else begin
        e = q2.pop_front();
        chk("fitness2", int'(fit2), e.fit);
        chk("perfect2", int'(perf2), e.perf);
        chk("done_cycle2", cyc, e.done_cyc);
      end
    end
  end

  task automatic launch0(input int mode, input logic [127:0] tt);
    @(negedge clk);
    mode0 = mode; tt0 = tt; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    chk("busy_start0", int'(busy0), 1);
    push0(ref_fit(mode, tt), cyc + 64);
  endtask

  task automatic launch2(input int mode, input logic [127:0] tt);
    @(negedge clk);
    mode2 = mode; tt2 = tt; start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("busy_start2", int'(busy2), 1);
    push2(ref_fit(mode, tt), cyc + 192);
  endtask

  task automatic drain0();
    int n;
    n = 0;
    while (q0.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chk("drain0_pending", q0.size(), 0);
    q0.delete();
  endtask

  task automatic drain2();
    int n;
    n = 0;
    while (q2.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chk("drain2_pending", q2.size(), 0);
    q2.delete();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int           t, n, bc, seen;
    logic [127:0] a, b, flip;
    checks = 0; errors = 0;
    rst_n = 1'b0; start0 = 1'b0; start2 = 1'b0;
    tt0 = '0; tt2 = '0; mode0 = 0; mode2 = 0;
    for (int i = 0; i < 64; i++) lut[i] = 2'($urandom);
    repeat (3) @(negedge clk);
    chk("rst_test_vec", int'(vec0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_fitness", int'(fit0), 0);
    chk("rst_perfect", int'(perf0), 0);
    rst_n = 1'b1;

    launch0(0, mk_tt(0)); drain0();
    chk("t1_fitness_hold", int'(fit0), 128);
    chk("t1_perfect_hold", int'(perf0), 1);
    launch0(0, ~mk_tt(0)); drain0();
    chk("t2_fitness_hold", int'(fit0), 0);
    launch0(1, '0); drain0();
    chk("t3_fitness_hold", int'(fit0), 64);

    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 64; i++) lut[i] = 2'($urandom);
      flip = '0;
      for (int f = 0; f < k; f++) flip[$urandom_range(127, 0)] = 1'b1;
      a = (k % 3 == 2) ? rand128() : (mk_tt(2) ^ flip);
      launch0(2, a); drain0();
    end

    // Reset mid-sweep: no done, everything back to reset values.
    launch0(0, mk_tt(0));
    n = 0;
    while (vec0 != 6'd20 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reach_vec20", int'(vec0), 20);
    rst_n = 1'b0;
    q0.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("t5_busy", int'(busy0), 0);
    chk("t5_test_vec", int'(vec0), 0);
    chk("t5_fitness", int'(fit0), 0);
    chk("t5_perfect", int'(perf0), 0);
    chk("t5_done", int'(done0), 0);
    repeat (80) @(negedge clk);
    launch0(1, rand128()); drain0();

    // Table change after acceptance, start held through FINISH.
    for (int i = 0; i < 64; i++) lut[i] = 2'($urandom);
    a = rand128(); b = rand128();
    @(negedge clk);
    mode0 = 2; tt0 = a; start0 = 1'b1;
    @(negedge clk);
    t = cyc;
    chk("t6_busy_start", int'(busy0), 1);
    push0(ref_fit(2, a), t + 64);
    repeat (5) @(negedge clk);
    tt0 = b;
    push0(ref_fit(2, b), t + 130);
    while (cyc < t + 65) @(negedge clk);
    chk("t6_idle_gap_busy", int'(busy0), 0);
    @(negedge clk);
    chk("t6_restart_busy", int'(busy0), 1);
    start0 = 1'b0;
    drain0();

    // SETTLE=2: extra start pulses during the sweep are ignored.
    mode2 = 0; tt2 = mk_tt(0);
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    t = cyc;
    chk("t4_busy_start", int'(busy2), 1);
    push2(ref_fit(0, tt2), t + 192);
    bc = 1; seen = 0;
    for (int i = 1; i <= 400; i++) begin
      @(negedge clk);
      start2 = (i == 10 || i == 100);
      if (done2) begin
        seen = 1;
        break;
      end
      if (busy2) bc++;
    end
    start2 = 1'b0;
    chk("t4_done_seen", seen, 1);
    chk("t4_busy_len", bc, 192);
    repeat (250) @(negedge clk);
    drain2();

    for (int i = 0; i < 64; i++) lut[i] = 2'($urandom);
    launch2(2, rand128()); drain2();
    launch2(1, mk_tt(1)); drain2();
    chk("t4_perfect_hold", int'(perf2), 1);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
